// File: rtl/serial_nbit_sub.sv
// Bit-serial N-bit unsigned subtractor with borrow-in/borrow-out.
// Operands are accepted in IDLE, one bit per clock in BUSY (LSB first), and the result is held in DONE until taken.
module serial_nbit_sub #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         b_out
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            br;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            d_bit;
    logic            br_nx;

    assign last  = (cnt == CW'(N - 1));
    assign d_bit = a_q[0] ^ b_q[0] ^ br;
    assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br);

    // Handshake outputs are decoded straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = BUSY;
            BUSY:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers shift right; diff fills from the MSB so it is aligned after N bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            b_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        br  <= b_in;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    a_q  <= {1'b0, a_q[N-1:1]};
                    b_q  <= {1'b0, b_q[N-1:1]};
                    br   <= br_nx;
                    diff <= {d_bit, diff[N-1:1]};
                    if (last) begin
                        b_out <= br_nx;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_nbit_sub.sv
// Directed and randomized self-checking bench for serial_nbit_sub at N = 8.
module tb_serial_nbit_sub;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         b_out;

    int tests;
    int fails;

    serial_nbit_sub #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set, wait for out_valid, check latency and result; leaves the block in DONE.
    task automatic issue(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic bin, input logic [N-1:0] ed, input logic eb);
        int lat;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        b_in     = bin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"},  32'(lat),   32'(N));
        check({tag, "_diff"}, 32'(diff),  32'(ed));
        check({tag, "_bout"}, 32'(b_out), 32'(eb));
    endtask

    // Complete the handshake and confirm the result persists in IDLE.
    task automatic drain(input string tag, input logic [N-1:0] ed, input logic eb);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
        check({tag, "_hold"}, 32'({b_out, diff}), 32'({eb, ed}));
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbin;
        logic [N:0]   exp;
        int           stall;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;

        #12;
        check("reset_state", 32'({in_ready, out_valid, b_out, diff}), 32'({3'b100, 8'h00}));
        rst_n = 1'b1;
        tick();

        issue("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        drain("basic", 8'h02, 1'b0);

        issue("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        drain("underflow", 8'hFF, 1'b1);

        issue("bin_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        drain("bin_ff", 8'hFF, 1'b1);

        issue("bin_80", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0);
        drain("bin_80", 8'h7F, 1'b0);

        // Backpressure: stall in DONE with noisy inputs.
        issue("bp", 8'h3C, 8'h1A, 1'b0, 8'h22, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 8'hA5 ^ 8'(i);
            b        = 8'h5A + 8'(i);
            b_in     = 1'(i);
            tick();
            check("bp_stall", 32'({in_ready, out_valid, b_out, diff}), 32'({3'b010, 8'h22}));
        end
        in_valid = 1'b0;
        drain("bp", 8'h22, 1'b0);

        // Reset mid-operation, asserted between clock edges.
        a        = 8'h77;
        b        = 8'h11;
        b_in     = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({in_ready, out_valid, b_out, diff}), 32'({3'b100, 8'h00}));
        #3;
        rst_n = 1'b1;
        tick();
        check("rst_no_valid", 32'(out_valid), 32'd0);
        issue("post_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        drain("post_rst", 8'h0F, 1'b0);

        // Randomized operands with random result stalls.
        for (int k = 0; k < 1000; k++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            exp  = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
            issue("rand", ra, rb, rbin, exp[N-1:0], exp[N]);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                tick();
                check("rand_stall", 32'({out_valid, b_out, diff}), 32'({1'b1, exp}));
            end
            drain("rand", exp[N-1:0], exp[N]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
